// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// The FSM state encoding, counter sizing and the signed-overflow rule live here.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

    // Overflow occurs when the operand signs differ and the result sign departs from the minuend's
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation for a single bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (bin & ~(a ^ b));
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor with valid/ready on both sides.
// Bit 0 is resolved on the accept edge, so the remaining WIDTH-1 bits take WIDTH-1 SHIFT cycles.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = cnt_w(WIDTH);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, diff_q;
    logic [WIDTH-2:0] diff_sh_q;
    logic [WIDTH-1:0] diff_sh_d;
    logic [CNT_W-1:0] cnt_q;
    logic             brw_q, borrow_q, ovf_q, a_msb_q, b_msb_q, run_q;
    logic             accept_s, last_s;
    logic             cell_a_s, cell_b_s, cell_bin_s, cell_d_s, cell_bo_s;

    assign accept_s  = in_valid & in_ready;
    assign last_s    = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
    assign diff_sh_d = {cell_d_s, diff_sh_q};

    // Cell sees raw operands on the accept cycle, shifted operands afterwards
    always_comb begin
        if (state_q == SHIFT) begin
            cell_a_s   = a_sh_q[0];
            cell_b_s   = b_sh_q[0];
            cell_bin_s = brw_q;
        end else begin
            cell_a_s   = a[0];
            cell_b_s   = b[0];
            cell_bin_s = borrow_in;
        end
    end

    full_subtractor u_cell (
        .a    (cell_a_s),
        .b    (cell_b_s),
        .bin  (cell_bin_s),
        .d    (cell_d_s),
        .bout (cell_bo_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = SHIFT;
                else          state_d = IDLE;
            end
            SHIFT: begin
                if (last_s) state_d = DONE;
                else        state_d = SHIFT;
            end
            DONE: begin
                if (accept_s)       state_d = SHIFT;
                else if (out_ready) state_d = IDLE;
                else                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM handshake outputs; in_ready stays low until the first edge after reset
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = run_q;
            end
            SHIFT: begin
                busy = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Operand shifters, borrow flop, bit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            brw_q     <= 1'b0;
            borrow_q  <= 1'b0;
            ovf_q     <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (accept_s) begin
                a_sh_q    <= {1'b0, a[WIDTH-1:1]};
                b_sh_q    <= {1'b0, b[WIDTH-1:1]};
                diff_sh_q <= diff_sh_d[WIDTH-1:1];
                brw_q     <= cell_bo_s;
                cnt_q     <= CNT_W'(1);
                a_msb_q   <= a[WIDTH-1];
                b_msb_q   <= b[WIDTH-1];
            end else if (state_q == SHIFT) begin
                a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
                diff_sh_q <= diff_sh_d[WIDTH-1:1];
                brw_q     <= cell_bo_s;
                if (last_s) begin
                    diff_q   <= diff_sh_d;
                    borrow_q <= cell_bo_s;
                    ovf_q    <= sub_ovf(a_msb_q, b_msb_q, cell_d_s);
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of the bit-serial subtractor at WIDTH=8.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, out_ready, borrow_in;
    logic [7:0] a, b;
    logic       in_ready, out_valid, borrow_out, ovf, busy;
    logic [7:0] diff;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[10];
    vec_t bvec[3];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One operation from IDLE: accept, scramble inputs, wait for result, optional stall, handshake
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi, input int stall,
                         output int lat, output logic [7:0] d, output logic bo, output logic ov);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a = av; b = bv; borrow_in = bi; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = ~av; b = ~bv; borrow_in = ~bi;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        repeat (stall) @(negedge clk);
        d = diff; bo = borrow_out; ov = ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int         lat, idx, res, since, seen;
        logic [7:0] d;
        logic       bo, ov;
        logic [8:0] r;
        logic [7:0] ra, rb;
        logic       rbi;

        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};
        vecs[8] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[9] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        bvec[0] = vecs[0];
        bvec[1] = vecs[1];
        bvec[2] = vecs[2];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; borrow_in = 1'b0; a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, lat, d, bo, ov);
            chk("vec_latency", 32'(lat), 32'd8);
            chk("vec_diff", 32'(d), 32'(vecs[i].d));
            chk("vec_borrow", 32'(bo), 32'(vecs[i].bo));
            chk("vec_ovf", 32'(ov), 32'(vecs[i].ov));
        end

        // Stall in DONE: 0x5C - 0x17 = 0x45
        @(negedge clk);
        a = 8'h5C; b = 8'h17; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = 8'hFF; b = 8'h00;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_diff", 32'(diff), 32'h45);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_after_valid", 32'(out_valid), 32'd0);
        chk("stall_diff_kept", 32'(diff), 32'h45);
        chk("stall_after_busy", 32'(busy), 32'd0);

        // Back-to-back with in_valid held high and junk operands during SHIFT
        @(negedge clk);
        a = bvec[0].a; b = bvec[0].b; borrow_in = bvec[0].bin; in_valid = 1'b1; out_ready = 1'b1;
        idx = 1; res = 0; since = 0;
        for (int guard = 0; guard < 60 && res < 3; guard++) begin
            @(negedge clk);
            since++;
            if (out_valid === 1'b1) begin
                chk("b2b_diff", 32'(diff), 32'(bvec[res].d));
                chk("b2b_borrow", 32'(borrow_out), 32'(bvec[res].bo));
                chk("b2b_ovf", 32'(ovf), 32'(bvec[res].ov));
                chk("b2b_gap", 32'(since), 32'd8);
                since = 0;
                res++;
                if (idx < 3) begin
                    a = bvec[idx].a; b = bvec[idx].b; borrow_in = bvec[idx].bin;
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                chk("b2b_busy", 32'(busy), 32'd1);
                a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
            end
        end
        chk("b2b_count", 32'(res), 32'd3);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;

        // Asynchronous reset during SHIFT cycle 4
        @(negedge clk);
        a = 8'h35; b = 8'h12; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_borrow", 32'(borrow_out), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_release_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("arst_no_output", 32'(seen), 32'd0);
        do_op(8'h35, 8'h12, 1'b0, 0, lat, d, bo, ov);
        chk("arst_new_latency", 32'(lat), 32'd8);
        chk("arst_new_diff", 32'(d), 32'h23);

        // Random operands with random output stalls against an arithmetic reference
        for (int n = 0; n < 300; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            do_op(ra, rb, rbi, $urandom_range(0, 3), lat, d, bo, ov);
            r = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            chk("rand_diff", 32'(d), 32'(r[7:0]));
            chk("rand_borrow", 32'(bo), 32'(r[8]));
            chk("rand_ovf", 32'(ov), 32'((ra[7] != rb[7]) && (r[7] != ra[7])));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
